memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage_pkg.sv | 33 +++
 rtl/load_store_aligner.sv | 42 ++++
 rtl/memory_access_stage.sv | 165 ++++++++++++++++
 tb/tb_memory_access_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared processor types for the memory access stage: the memory access size,
// the misalignment trap causes, the stage FSM states and an alignment helper.
package memory_access_stage_pkg;

  typedef logic [31:0] word_t;

  // Encoding matches the exMemSize port; the reserved code behaves as a word.
  typedef enum logic [1:0] {
    MEM_BYTE      = 2'd0,
    MEM_HALF      = 2'd1,
    MEM_WORD      = 2'd2,
    MEM_WORD_RSVD = 2'd3
  } mem_access_size_e;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ma_state_e;

  // True when the access does not sit on its natural boundary.
  function automatic logic is_misaligned(input mem_access_size_e size,
                                         input logic [1:0] offset);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return offset[0];
      default:  return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_aligner.sv
// Lane steering for stores (byte enables, replicated data) and lane
// extraction plus sign/zero extension for loads. Purely combinational.
module load_store_aligner
  import memory_access_stage_pkg::*;
(
  input  mem_access_size_e size,
  input  logic [1:0]       offset,
  input  logic             load_unsigned,
  input  word_t            store_data,
  input  word_t            read_data,
  output logic [3:0]       byte_enable,
  output word_t            write_data,
  output word_t            load_value
);

  word_t shifted;

  // Bring the addressed byte lane down to bit 0 of the load word.
  assign shifted = read_data >> {offset, 3'b000};

  // Select enables, store lanes and load extension by access size.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    byte_enable = 4'hF;
    write_data  = store_data;
    load_value  = shifted;
    case (size)
      MEM_BYTE: begin
        byte_enable = 4'b0001 << offset;
        write_data  = {4{store_data[7:0]}};
        load_value  = {{24{~load_unsigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        byte_enable = 4'b0011 << {offset[1], 1'b0};
        write_data  = {2{store_data[15:0]}};
        load_value  = {{16{~load_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: passes non-memory results straight through,
// traps misaligned accesses, and runs one data-cache transaction at a time
// for aligned loads and stores, stalling upstream while it waits for dcAck.
module memory_access_stage
  import memory_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        exValid,
  input  word_t       exPc,
  input  logic        exIsLoad,
  input  logic        exIsStore,
  input  logic [1:0]  exMemSize,
  input  logic        exLoadUnsigned,
  input  word_t       exAddr,
  input  word_t       exStoreData,
  input  logic [4:0]  exDstRegAddr,
  input  logic        exRegWrite,
  input  word_t       exIntResult,
  input  logic        exTrapValid,
  input  logic [3:0]  exTrapCause,
  input  word_t       exTrapValue,
  input  logic        flush,
  output logic        stall,
  output logic        dcReq,
  output logic        dcWrite,
  output word_t       dcAddr,
  output word_t       dcWriteData,
  output logic [3:0]  dcByteEnable,
  input  logic        dcAck,
  input  word_t       dcReadData,
  output logic        maValid,
  output word_t       maPc,
  output logic [4:0]  maDstRegAddr,
  output logic        maRegWrite,
  output word_t       maRegValue,
  output logic        maTrapValid,
  output logic [3:0]  maTrapCause,
  output word_t       maTrapValue
);

  ma_state_e        state_q, state_d;
  mem_access_size_e ex_size, req_size_q, sel_size;
  logic [1:0]       req_offset_q, sel_offset;
  logic             req_unsigned_q, req_is_load_q, req_reg_write_q;
  logic             flush_pending_q;
  logic             accept, is_mem, misaligned, start_mem, ack_busy;
  logic [3:0]       al_byte_enable;
  word_t            al_write_data, al_load_value;

  assign ex_size    = mem_access_size_e'(exMemSize);
  assign accept     = (state_q == ST_IDLE) && exValid && !flush;
  assign is_mem     = exIsLoad || exIsStore;
  assign misaligned = is_misaligned(ex_size, exAddr[1:0]);
  assign start_mem  = accept && is_mem && !exTrapValid && !misaligned;
  assign ack_busy   = (state_q == ST_BUSY) && dcAck;

  assign stall = (state_q == ST_BUSY);
  assign dcReq = (state_q == ST_BUSY);

  // While idle the aligner steers the incoming store; while busy it decodes
  // the returning read word using the latched size and offset.
  assign sel_size   = (state_q == ST_BUSY) ? req_size_q   : ex_size;
  assign sel_offset = (state_q == ST_BUSY) ? req_offset_q : exAddr[1:0];

  load_store_aligner u_aligner (
    .size          (sel_size),
    .offset        (sel_offset),
    .load_unsigned (req_unsigned_q),
    .store_data    (exStoreData),
    .read_data     (dcReadData),
    .byte_enable   (al_byte_enable),
    .write_data    (al_write_data),
    .load_value    (al_load_value)
  );

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: enter BUSY on an aligned memory op, leave on dcAck.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_mem) state_d = ST_BUSY;
      ST_BUSY: if (dcAck)     state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result, trap, cache request and pending-flush registers.
  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: these are plain registers rather than a memory array, so every one
    // is cleared by reset; outputs and the pending-flush flag start at zero.
    if (!rstN) begin
      maValid         <= 1'b0;
      maPc            <= '0;
      maDstRegAddr    <= '0;
      maRegWrite      <= 1'b0;
      maRegValue      <= '0;
      maTrapValid     <= 1'b0;
      maTrapCause     <= '0;
      maTrapValue     <= '0;
      dcWrite         <= 1'b0;
      dcAddr          <= '0;
      dcWriteData     <= '0;
      dcByteEnable    <= '0;
      req_size_q      <= MEM_BYTE;
      req_offset_q    <= '0;
      req_unsigned_q  <= 1'b0;
      req_is_load_q   <= 1'b0;
      req_reg_write_q <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      maValid     <= 1'b0;
      maTrapValid <= 1'b0;
      if (accept) begin
        maPc         <= exPc;
        maDstRegAddr <= exDstRegAddr;
        maRegValue   <= exIntResult;
        if (exTrapValid) begin
          maValid     <= 1'b1;
          maTrapValid <= 1'b1;
          maTrapCause <= exTrapCause;
          maTrapValue <= exTrapValue;
          maRegWrite  <= 1'b0;
        end else if (is_mem && misaligned) begin
          maValid     <= 1'b1;
          maTrapValid <= 1'b1;
          maTrapCause <= exIsLoad ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
          maTrapValue <= exAddr;
          maRegWrite  <= 1'b0;
        end else if (is_mem) begin
          maRegWrite      <= 1'b0;
          dcAddr          <= {exAddr[31:2], 2'b00};
          dcWrite         <= !exIsLoad;
          dcWriteData     <= al_write_data;
          dcByteEnable    <= al_byte_enable;
          req_size_q      <= ex_size;
          req_offset_q    <= exAddr[1:0];
          req_unsigned_q  <= exLoadUnsigned;
          req_is_load_q   <= exIsLoad;
          req_reg_write_q <= exRegWrite;
        end else begin
          maValid    <= 1'b1;
          maRegWrite <= exRegWrite;
        end
      end
      if (ack_busy) begin
        maValid    <= !(flush_pending_q || flush);
        maRegWrite <= req_is_load_q && req_reg_write_q;
        maRegValue <= req_is_load_q ? al_load_value : '0;
      end
      // A flush seen while busy discards the outstanding result.
      if (state_q == ST_BUSY) begin
        if (dcAck)      flush_pending_q <= 1'b0;
        else if (flush) flush_pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: a table of single-op vectors
// with hand-computed results, then directed multi-cycle sequences for flush,
// stray acks, back-to-back accept timing and reset during a transaction.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        exValid, exIsLoad, exIsStore, exLoadUnsigned, exRegWrite, exTrapValid, flush;
  logic [1:0]  exMemSize;
  logic [4:0]  exDstRegAddr;
  logic [3:0]  exTrapCause;
  word_t       exPc, exAddr, exStoreData, exIntResult, exTrapValue;
  logic        stall, dcReq, dcWrite, dcAck;
  word_t       dcAddr, dcWriteData, dcReadData;
  logic [3:0]  dcByteEnable;
  logic        maValid, maRegWrite, maTrapValid;
  word_t       maPc, maRegValue, maTrapValue;
  logic [4:0]  maDstRegAddr;
  logic [3:0]  maTrapCause;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk(clk), .rstN(rstN), .exValid(exValid), .exPc(exPc), .exIsLoad(exIsLoad),
    .exIsStore(exIsStore), .exMemSize(exMemSize), .exLoadUnsigned(exLoadUnsigned),
    .exAddr(exAddr), .exStoreData(exStoreData), .exDstRegAddr(exDstRegAddr),
    .exRegWrite(exRegWrite), .exIntResult(exIntResult), .exTrapValid(exTrapValid),
    .exTrapCause(exTrapCause), .exTrapValue(exTrapValue), .flush(flush),
    .stall(stall), .dcReq(dcReq), .dcWrite(dcWrite), .dcAddr(dcAddr),
    .dcWriteData(dcWriteData), .dcByteEnable(dcByteEnable), .dcAck(dcAck),
    .dcReadData(dcReadData), .maValid(maValid), .maPc(maPc),
    .maDstRegAddr(maDstRegAddr), .maRegWrite(maRegWrite), .maRegValue(maRegValue),
    .maTrapValid(maTrapValid), .maTrapCause(maTrapCause), .maTrapValue(maTrapValue)
  );

  typedef struct {
    logic        is_load, is_store;
    logic [1:0]  size;
    logic        unsgn;
    logic [31:0] addr, sdata, rdata, intres;
    logic        tvalid;
    logic [3:0]  tcause;
    logic [31:0] tvalue;
    int          delay;
    logic        exp_mem;
    logic [31:0] exp_dcaddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_trap;
    logic [3:0]  exp_cause;
    logic [31:0] exp_tvalue;
    logic [31:0] exp_value;
    logic        exp_rw;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic ld, input logic st,
                        input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] intres, input logic [4:0] rd);
    exValid = 1'b1; exPc = pc; exIsLoad = ld; exIsStore = st; exMemSize = size;
    exLoadUnsigned = uns; exAddr = addr; exStoreData = sdata; exIntResult = intres;
    exDstRegAddr = rd; exRegWrite = 1'b1; exTrapValid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    string n;
    int    stall_cycles;
    v = vecs[i];
    n = $sformatf("v%0d", i);
    @(negedge clk);
    set_op(32'h100 + 32'(i * 4), v.is_load, v.is_store, v.size, v.unsgn, v.addr,
           v.sdata, v.intres, 5'(i + 1));
    exTrapValid = v.tvalid; exTrapCause = v.tcause; exTrapValue = v.tvalue;
    @(negedge clk);
    exValid = 1'b0; exTrapValid = 1'b0;
    if (!v.exp_mem) begin
      check({n, "_maValid"}, 32'(maValid), 32'd1);
      check({n, "_dcReq"}, 32'(dcReq), 32'd0);
      check({n, "_stall"}, 32'(stall), 32'd0);
      check({n, "_trapValid"}, 32'(maTrapValid), 32'(v.exp_trap));
      if (v.exp_trap) begin
        check({n, "_trapCause"}, 32'(maTrapCause), 32'(v.exp_cause));
        check({n, "_trapValue"}, maTrapValue, v.exp_tvalue);
      end
      check({n, "_regValue"}, maRegValue, v.exp_value);
      if (!v.tvalid) check({n, "_regWrite"}, 32'(maRegWrite), 32'(v.exp_rw));
    end else begin
      stall_cycles = 0;
      check({n, "_maValidEarly"}, 32'(maValid), 32'd0);
      check({n, "_dcReq"}, 32'(dcReq), 32'd1);
      check({n, "_dcAddr"}, dcAddr, v.exp_dcaddr);
      check({n, "_dcWrite"}, 32'(dcWrite), 32'(v.is_store));
      check({n, "_dcByteEnable"}, 32'(dcByteEnable), 32'(v.exp_be));
      if (v.is_store) check({n, "_dcWriteData"}, dcWriteData, v.exp_wdata);
      stall_cycles += int'(stall);
      for (int k = 0; k < v.delay; k++) begin
        @(negedge clk);
        stall_cycles += int'(stall);
        check({n, "_dcReqHeld"}, 32'(dcReq), 32'd1);
        check({n, "_dcAddrHeld"}, dcAddr, v.exp_dcaddr);
        check({n, "_dcBeHeld"}, 32'(dcByteEnable), 32'(v.exp_be));
      end
      dcAck = 1'b1; dcReadData = v.rdata;
      @(negedge clk);
      dcAck = 1'b0; dcReadData = 32'h5A5A_5A5A;
      check({n, "_stallCycles"}, 32'(stall_cycles), 32'(v.delay + 1));
      check({n, "_stallDone"}, 32'(stall), 32'd0);
      check({n, "_dcReqDone"}, 32'(dcReq), 32'd0);
      check({n, "_maValid"}, 32'(maValid), 32'd1);
      check({n, "_trapValid"}, 32'(maTrapValid), 32'd0);
      check({n, "_regWrite"}, 32'(maRegWrite), 32'(v.exp_rw));
      if (v.is_load) check({n, "_regValue"}, maRegValue, v.exp_value);
    end
    check({n, "_pc"}, maPc, 32'h100 + 32'(i * 4));
    check({n, "_rd"}, 32'(maDstRegAddr), 32'(i + 1));
    @(negedge clk);
    check({n, "_pulse"}, 32'(maValid), 32'd0);
  endtask

  initial begin
    // is_load is_store size uns addr sdata rdata intres tvalid tcause tvalue delay |
    // exp_mem dcaddr be wdata trap cause tvalue value rw
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1234, 1'b0, 4'd0, 32'h0, 0,
                 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h1234, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF_FF00, 32'h0, 1'b0, 4'd0, 32'h0, 3,
                 1'b1, 32'h1000, 4'b1000, 32'h0, 1'b0, 4'd0, 32'h0, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0, 0,
                 1'b1, 32'h2000, 4'b1100, 32'hABCD_ABCD, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 32'h77, 1'b0, 4'd0, 32'h0, 0,
                 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'd4, 32'h3001, 32'h77, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 32'h1234_80AB, 32'h0, 1'b0, 4'd0, 32'h0, 1,
                 1'b1, 32'h1000, 4'b0010, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0000_0080, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 32'h8001_0000, 32'h0, 1'b0, 4'd0, 32'h0, 0,
                 1'b1, 32'h1000, 4'b1100, 32'h0, 1'b0, 4'd0, 32'h0, 32'hFFFF_8001, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h1000, 32'h0, 32'h0000_F00D, 32'h0, 1'b0, 4'd0, 32'h0, 2,
                 1'b1, 32'h1000, 4'b0011, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0000_F00D, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'd0, 32'h0, 1,
                 1'b1, 32'h4000, 4'hF, 32'h0, 1'b0, 4'd0, 32'h0, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h5001, 32'h1234_56A5, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0, 0,
                 1'b1, 32'h5000, 4'b0010, 32'hA5A5_A5A5, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h6004, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0, 1,
                 1'b1, 32'h6004, 4'hF, 32'hCAFE_F00D, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h7001, 32'h0, 32'h0, 32'h99, 1'b0, 4'd0, 32'h0, 0,
                 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'd6, 32'h7001, 32'h99, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h8003, 32'h0, 32'h0, 32'hAA, 1'b1, 4'd2, 32'h55, 0,
                 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'd2, 32'h55, 32'hAA, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h9002, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0, 0,
                 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 4'd4, 32'h9002, 32'h0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h1000, 32'h0, 32'hFFFF_7FFF, 32'h0, 1'b0, 4'd0, 32'h0, 0,
                 1'b1, 32'h1000, 4'b0011, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0000_7FFF, 1'b1};

    rstN = 1'b0; exValid = 1'b0; exPc = '0; exIsLoad = 1'b0; exIsStore = 1'b0;
    exMemSize = '0; exLoadUnsigned = 1'b0; exAddr = '0; exStoreData = '0;
    exDstRegAddr = '0; exRegWrite = 1'b0; exIntResult = '0; exTrapValid = 1'b0;
    exTrapCause = '0; exTrapValue = '0; flush = 1'b0; dcAck = 1'b0; dcReadData = '0;

    // Reset state.
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dcReq", 32'(dcReq), 32'd0);
    check("rst_maValid", 32'(maValid), 32'd0);
    check("rst_trapValid", 32'(maTrapValid), 32'd0);
    check("rst_regValue", maRegValue, 32'd0);
    check("rst_dcByteEnable", 32'(dcByteEnable), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Flush in IDLE: neither an ALU op nor a load is accepted.
    @(negedge clk);
    set_op(32'h200, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h42, 5'd3);
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_alu_maValid", 32'(maValid), 32'd0);
    set_op(32'h204, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    exValid = 1'b0; flush = 1'b0;
    check("flush_idle_ld_dcReq", 32'(dcReq), 32'd0);
    check("flush_idle_ld_stall", 32'(stall), 32'd0);
    check("flush_idle_ld_maValid", 32'(maValid), 32'd0);

    // Stray dcAck while idle.
    dcAck = 1'b1; dcReadData = 32'h1111_1111;
    @(negedge clk);
    dcAck = 1'b0;
    check("stray_ack_maValid", 32'(maValid), 32'd0);
    check("stray_ack_stall", 32'(stall), 32'd0);

    // Flush while BUSY: request held to the ack, result dropped.
    set_op(32'h300, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 5'd7);
    @(negedge clk);
    exValid = 1'b0;
    check("flush_busy_dcReq0", 32'(dcReq), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_dcReq1", 32'(dcReq), 32'd1);
    check("flush_busy_addr", dcAddr, 32'h4000);
    @(negedge clk);
    check("flush_busy_dcReq2", 32'(dcReq), 32'd1);
    dcAck = 1'b1; dcReadData = 32'h2222_2222;
    @(negedge clk);
    dcAck = 1'b0;
    check("flush_busy_maValid", 32'(maValid), 32'd0);
    check("flush_busy_stall", 32'(stall), 32'd0);
    run_vec(0);

    // Op held upstream during the ack cycle is accepted the cycle after.
    @(negedge clk);
    set_op(32'h400, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 5'd9);
    @(negedge clk);
    set_op(32'h500, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h2222, 5'd10);
    check("b2b_stall_ack_cycle", 32'(stall), 32'd1);
    dcAck = 1'b1; dcReadData = 32'h1111_1111;
    @(negedge clk);
    dcAck = 1'b0;
    check("b2b_load_maValid", 32'(maValid), 32'd1);
    check("b2b_load_value", maRegValue, 32'h1111_1111);
    check("b2b_load_pc", maPc, 32'h400);
    @(negedge clk);
    exValid = 1'b0;
    check("b2b_alu_maValid", 32'(maValid), 32'd1);
    check("b2b_alu_value", maRegValue, 32'h2222);
    check("b2b_alu_pc", maPc, 32'h500);
    @(negedge clk);
    check("b2b_pulse", 32'(maValid), 32'd0);

    // Reset while BUSY drops the request at once; a late ack is ignored.
    set_op(32'h600, 1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 5'd11);
    @(negedge clk);
    exValid = 1'b0;
    check("rst_busy_dcReq_before", 32'(dcReq), 32'd1);
    #1 rstN = 1'b0;
    #1;
    check("rst_busy_dcReq", 32'(dcReq), 32'd0);
    check("rst_busy_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    dcAck = 1'b1; dcReadData = 32'h3333_3333;
    @(negedge clk);
    dcAck = 1'b0;
    check("rst_late_ack_maValid", 32'(maValid), 32'd0);
    check("rst_late_ack_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("rst_late_ack_maValid2", 32'(maValid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
